// File: rtl/ysyx_24080006_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the load/store unit.
// Purely declarative: no logic, no latency.
// Not applicable to backpressure.
package ysyx_24080006_pkg;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2
   } mem_op_e;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_OUT  = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/ysyx_24080006_lsu_align.sv
`timescale 1ns/1ps
// Access legality check, store lane formatting and load extraction/extension.
// Purely combinational, zero latency.
// No handshake; the caller decides when the outputs are used.
module ysyx_24080006_lsu_align
   import ysyx_24080006_pkg::*;
(
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic        bad,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_val
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Illegal funct3 for the access kind, or a misaligned halfword/word address
   always_comb begin
      bad = 1'b0;
      if (is_load) begin
         case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = addr_lo[0];
            F3_W:        bad = |addr_lo;
            default:     bad = 1'b1;
         endcase
      end else if (is_store) begin
         case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = |addr_lo;
            default: bad = 1'b1;
         endcase
      end
   end

   // Byte enables and lane-replicated write data for stores
   always_comb begin
      wstrb = 4'b1111;
      wdata = store_data;
      case (funct3)
         F3_B: begin
            wstrb = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         F3_H: begin
            wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            wstrb = 4'b1111;
            wdata = store_data;
         end
      endcase
   end

   // Pick the addressed byte/halfword out of the aligned word and extend it
   always_comb begin
      byte_v   = rdata[{addr_lo, 3'b000} +: 8];
      half_v   = rdata[{addr_lo[1], 4'b0000} +: 16];
      load_val = rdata;
      case (funct3)
         F3_B:    load_val = {{24{byte_v[7]}}, byte_v};
         F3_BU:   load_val = {24'd0, byte_v};
         F3_H:    load_val = {{16{half_v[15]}}, half_v};
         F3_HU:   load_val = {16'd0, half_v};
         default: load_val = rdata;
      endcase
   end

endmodule

// File: rtl/ysyx_24080006_lsu.sv
`timescale 1ns/1ps
// Load/store stage: one optional data-memory access between EXU and WBU.
// Latency: 1 cycle for non-memory ops, 3+ cycles for memory ops (plus bus waits).
// Backpressure: exu_ready only in IDLE; holds request/result until bus/WBU ready.
module ysyx_24080006_lsu
   import ysyx_24080006_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        exu_valid,
   output logic        exu_ready,
   input  logic [31:0] exu_alu_res,
   input  logic [31:0] exu_store_data,
   input  logic [1:0]  exu_mem_op,
   input  logic [2:0]  exu_funct3,
   input  logic [4:0]  exu_rd_addr,
   input  logic        exu_wb,
   input  logic [31:0] exu_dnpc,
   input  logic        exu_jump,
   input  logic        exu_branch,
   output logic        wbu_valid,
   input  logic        wbu_ready,
   output logic [31:0] wbu_alu_res,
   output logic [4:0]  wbu_rd_addr,
   output logic        wbu_wb,
   output logic [31:0] wbu_dnpc,
   output logic        wbu_jump,
   output logic        wbu_branch,
   output logic        wbu_fault,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wstrb,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_rdata,
   input  logic        mem_resp_err
);

   lsu_state_e  state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        is_load_q, is_load_d;
   logic        wbu_valid_q, wbu_valid_d;
   logic [31:0] wbu_alu_res_q, wbu_alu_res_d;
   logic [4:0]  wbu_rd_addr_q, wbu_rd_addr_d;
   logic        wbu_wb_q, wbu_wb_d;
   logic [31:0] wbu_dnpc_q, wbu_dnpc_d;
   logic        wbu_jump_q, wbu_jump_d;
   logic        wbu_branch_q, wbu_branch_d;
   logic        wbu_fault_q, wbu_fault_d;
   logic        mem_req_valid_q, mem_req_valid_d;
   logic [31:0] mem_req_addr_q, mem_req_addr_d;
   logic        mem_req_wen_q, mem_req_wen_d;
   logic [31:0] mem_req_wdata_q, mem_req_wdata_d;
   logic [3:0]  mem_req_wstrb_q, mem_req_wstrb_d;

   logic        in_idle;
   logic        exu_is_load, exu_is_store;
   logic        al_is_load, al_is_store;
   logic [2:0]  al_funct3;
   logic [1:0]  al_addr_lo;
   logic        al_bad;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata, al_load_val;

   assign in_idle      = (state_q == S_IDLE);
   assign exu_ready    = in_idle;
   assign exu_is_load  = (exu_mem_op == MEM_LOAD);
   assign exu_is_store = (exu_mem_op == MEM_STORE);

   // The aligner sees the incoming instruction in IDLE and the latched access afterwards
   assign al_is_load  = in_idle ? exu_is_load  : is_load_q;
   assign al_is_store = in_idle ? exu_is_store : 1'b0;
   assign al_funct3   = in_idle ? exu_funct3   : funct3_q;
   assign al_addr_lo  = in_idle ? exu_alu_res[1:0] : mem_req_addr_q[1:0];

   ysyx_24080006_lsu_align u_align (
      .is_load    (al_is_load),
      .is_store   (al_is_store),
      .funct3     (al_funct3),
      .addr_lo    (al_addr_lo),
      .store_data (exu_store_data),
      .rdata      (mem_resp_rdata),
      .bad        (al_bad),
      .wstrb      (al_wstrb),
      .wdata      (al_wdata),
      .load_val   (al_load_val)
   );

   // Next-state and next-output decode for the IDLE/REQ/RESP/OUT sequence
   always_comb begin
      state_d         = state_q;
      funct3_d        = funct3_q;
      is_load_d       = is_load_q;
      wbu_valid_d     = wbu_valid_q;
      wbu_alu_res_d   = wbu_alu_res_q;
      wbu_rd_addr_d   = wbu_rd_addr_q;
      wbu_wb_d        = wbu_wb_q;
      wbu_dnpc_d      = wbu_dnpc_q;
      wbu_jump_d      = wbu_jump_q;
      wbu_branch_d    = wbu_branch_q;
      wbu_fault_d     = wbu_fault_q;
      mem_req_valid_d = mem_req_valid_q;
      mem_req_addr_d  = mem_req_addr_q;
      mem_req_wen_d   = mem_req_wen_q;
      mem_req_wdata_d = mem_req_wdata_q;
      mem_req_wstrb_d = mem_req_wstrb_q;
      case (state_q)
         S_IDLE: begin
            if (exu_valid) begin
               funct3_d      = exu_funct3;
               is_load_d     = exu_is_load;
               wbu_alu_res_d = exu_alu_res;
               wbu_rd_addr_d = exu_rd_addr;
               wbu_dnpc_d    = exu_dnpc;
               wbu_jump_d    = exu_jump;
               wbu_branch_d  = exu_branch;
               wbu_fault_d   = 1'b0;
               if (!exu_is_load && !exu_is_store) begin
                  wbu_wb_d    = exu_wb;
                  wbu_valid_d = 1'b1;
                  state_d     = S_OUT;
               end else if (al_bad) begin
                  wbu_wb_d    = 1'b0;
                  wbu_fault_d = 1'b1;
                  wbu_valid_d = 1'b1;
                  state_d     = S_OUT;
               end else begin
                  // Stores never write rd; loads keep the EXU's write enable
                  wbu_wb_d        = exu_is_load ? exu_wb : 1'b0;
                  mem_req_valid_d = 1'b1;
                  mem_req_addr_d  = exu_alu_res;
                  mem_req_wen_d   = exu_is_store;
                  mem_req_wdata_d = al_wdata;
                  mem_req_wstrb_d = exu_is_store ? al_wstrb : 4'b0000;
                  state_d         = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               mem_req_valid_d = 1'b0;
               state_d         = S_RESP;
            end
         end
         S_RESP: begin
            if (mem_resp_valid) begin
               if (mem_resp_err) begin
                  wbu_fault_d = 1'b1;
                  wbu_wb_d    = 1'b0;
               end else if (is_load_q) begin
                  wbu_alu_res_d = al_load_val;
               end
               wbu_valid_d = 1'b1;
               state_d     = S_OUT;
            end
         end
         S_OUT: begin
            if (wbu_ready) begin
               wbu_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs, cleared by synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         funct3_q        <= 3'd0;
         is_load_q       <= 1'b0;
         wbu_valid_q     <= 1'b0;
         wbu_alu_res_q   <= 32'd0;
         wbu_rd_addr_q   <= 5'd0;
         wbu_wb_q        <= 1'b0;
         wbu_dnpc_q      <= 32'd0;
         wbu_jump_q      <= 1'b0;
         wbu_branch_q    <= 1'b0;
         wbu_fault_q     <= 1'b0;
         mem_req_valid_q <= 1'b0;
         mem_req_addr_q  <= 32'd0;
         mem_req_wen_q   <= 1'b0;
         mem_req_wdata_q <= 32'd0;
         mem_req_wstrb_q <= 4'd0;
      end else begin
         state_q         <= state_d;
         funct3_q        <= funct3_d;
         is_load_q       <= is_load_d;
         wbu_valid_q     <= wbu_valid_d;
         wbu_alu_res_q   <= wbu_alu_res_d;
         wbu_rd_addr_q   <= wbu_rd_addr_d;
         wbu_wb_q        <= wbu_wb_d;
         wbu_dnpc_q      <= wbu_dnpc_d;
         wbu_jump_q      <= wbu_jump_d;
         wbu_branch_q    <= wbu_branch_d;
         wbu_fault_q     <= wbu_fault_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_req_addr_q  <= mem_req_addr_d;
         mem_req_wen_q   <= mem_req_wen_d;
         mem_req_wdata_q <= mem_req_wdata_d;
         mem_req_wstrb_q <= mem_req_wstrb_d;
      end
   end

   assign wbu_valid     = wbu_valid_q;
   assign wbu_alu_res   = wbu_alu_res_q;
   assign wbu_rd_addr   = wbu_rd_addr_q;
   assign wbu_wb        = wbu_wb_q;
   assign wbu_dnpc      = wbu_dnpc_q;
   assign wbu_jump      = wbu_jump_q;
   assign wbu_branch    = wbu_branch_q;
   assign wbu_fault     = wbu_fault_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_addr  = mem_req_addr_q;
   assign mem_req_wen   = mem_req_wen_q;
   assign mem_req_wdata = mem_req_wdata_q;
   assign mem_req_wstrb = mem_req_wstrb_q;

endmodule

// File: tb/tb_ysyx_24080006_lsu.sv
`timescale 1ns/1ps
// Directed bench for the load/store stage.
// Drives and samples on the falling clock edge, away from the active edge.
// Bus and WBU stalls are produced by holding ready/response signals low.
module tb_ysyx_24080006_lsu;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        exu_valid = 1'b0;
   logic        exu_ready;
   logic [31:0] exu_alu_res = '0;
   logic [31:0] exu_store_data = '0;
   logic [1:0]  exu_mem_op = '0;
   logic [2:0]  exu_funct3 = '0;
   logic [4:0]  exu_rd_addr = '0;
   logic        exu_wb = 1'b0;
   logic [31:0] exu_dnpc = '0;
   logic        exu_jump = 1'b0;
   logic        exu_branch = 1'b0;
   logic        wbu_valid;
   logic        wbu_ready = 1'b0;
   logic [31:0] wbu_alu_res;
   logic [4:0]  wbu_rd_addr;
   logic        wbu_wb;
   logic [31:0] wbu_dnpc;
   logic        wbu_jump;
   logic        wbu_branch;
   logic        wbu_fault;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_rdata = '0;
   logic        mem_resp_err = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int bus_xfers = 0;
   int xfers0;

   ysyx_24080006_lsu dut (
      .clock(clock), .reset(reset),
      .exu_valid(exu_valid), .exu_ready(exu_ready),
      .exu_alu_res(exu_alu_res), .exu_store_data(exu_store_data),
      .exu_mem_op(exu_mem_op), .exu_funct3(exu_funct3),
      .exu_rd_addr(exu_rd_addr), .exu_wb(exu_wb), .exu_dnpc(exu_dnpc),
      .exu_jump(exu_jump), .exu_branch(exu_branch),
      .wbu_valid(wbu_valid), .wbu_ready(wbu_ready),
      .wbu_alu_res(wbu_alu_res), .wbu_rd_addr(wbu_rd_addr), .wbu_wb(wbu_wb),
      .wbu_dnpc(wbu_dnpc), .wbu_jump(wbu_jump), .wbu_branch(wbu_branch),
      .wbu_fault(wbu_fault),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
      .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .mem_resp_err(mem_resp_err)
   );

   always #5 clock = ~clock;

   // Count bus request handshakes seen by the memory side
   always @(posedge clock) begin
      if (reset && mem_req_valid && mem_req_ready) bus_xfers++;
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one instruction in IDLE and let it be accepted on the next edge
   task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd, input logic wb);
      chk("exu_ready_before_issue", {31'd0, exu_ready}, 32'd1);
      exu_mem_op     = op;
      exu_funct3     = f3;
      exu_alu_res    = addr;
      exu_store_data = sdata;
      exu_rd_addr    = rd;
      exu_wb         = wb;
      exu_valid      = 1'b1;
      tick();
      exu_valid      = 1'b0;
   endtask

   // Act as the memory: stall the request, optionally inject a stray response, then respond
   task automatic serve(input int req_wait, input int resp_wait, input logic [31:0] rdata,
                        input logic err, input logic spurious, input logic [31:0] ex_addr,
                        input logic ex_wen, input logic [3:0] ex_wstrb, input logic [31:0] ex_wdata);
      chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("req_addr", mem_req_addr, ex_addr);
      chk("req_wen", {31'd0, mem_req_wen}, {31'd0, ex_wen});
      chk("req_wstrb", {28'd0, mem_req_wstrb}, {28'd0, ex_wstrb});
      chk("req_wdata", mem_req_wdata, ex_wdata);
      for (int i = 0; i < req_wait; i++) begin
         mem_resp_valid = spurious;
         mem_resp_rdata = 32'hDEAD_DEAD;
         tick();
         chk("req_valid_hold", {31'd0, mem_req_valid}, 32'd1);
         chk("req_addr_hold", mem_req_addr, ex_addr);
         chk("req_wstrb_hold", {28'd0, mem_req_wstrb}, {28'd0, ex_wstrb});
         chk("req_wdata_hold", mem_req_wdata, ex_wdata);
         chk("wbu_valid_in_req", {31'd0, wbu_valid}, 32'd0);
      end
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      chk("req_valid_drop", {31'd0, mem_req_valid}, 32'd0);
      for (int i = 0; i < resp_wait; i++) begin
         tick();
         chk("wbu_valid_in_resp", {31'd0, wbu_valid}, 32'd0);
      end
      mem_resp_valid = 1'b1;
      mem_resp_rdata = rdata;
      mem_resp_err   = err;
      tick();
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
   endtask

   // Act as the WBU: stall for out_wait cycles, check the result, then accept it
   task automatic retire(input int out_wait, input logic chk_res, input logic [31:0] ex_res,
                         input logic ex_wb, input logic ex_fault);
      for (int i = 0; i < out_wait; i++) begin
         chk("wbu_valid_hold", {31'd0, wbu_valid}, 32'd1);
         if (chk_res) chk("wbu_res_hold", wbu_alu_res, ex_res);
         tick();
      end
      chk("wbu_valid", {31'd0, wbu_valid}, 32'd1);
      if (chk_res) chk("wbu_alu_res", wbu_alu_res, ex_res);
      chk("wbu_wb", {31'd0, wbu_wb}, {31'd0, ex_wb});
      chk("wbu_fault", {31'd0, wbu_fault}, {31'd0, ex_fault});
      chk("exu_ready_in_out", {31'd0, exu_ready}, 32'd0);
      wbu_ready = 1'b1;
      tick();
      wbu_ready = 1'b0;
      chk("wbu_valid_clear", {31'd0, wbu_valid}, 32'd0);
   endtask

   initial begin
      // Reset with a pending EXU instruction
      reset = 1'b0;
      exu_valid = 1'b1;
      exu_alu_res = 32'h0000_00AA;
      tick();
      tick();
      chk("rst_wbu_valid", {31'd0, wbu_valid}, 32'd0);
      chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_alu_res", wbu_alu_res, 32'd0);
      chk("rst_exu_ready", {31'd0, exu_ready}, 32'd1);
      exu_valid = 1'b0;
      reset = 1'b1;
      tick();
      chk("post_rst_wbu_valid", {31'd0, wbu_valid}, 32'd0);
      chk("post_rst_fault", {31'd0, wbu_fault}, 32'd0);
      chk("post_rst_exu_ready", {31'd0, exu_ready}, 32'd1);

      // NONE pass-through with forwarded control fields
      exu_dnpc = 32'h8000_0104;
      exu_jump = 1'b1;
      exu_branch = 1'b0;
      issue(2'd0, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
      chk("none_valid_t1", {31'd0, wbu_valid}, 32'd1);
      chk("none_rd", {27'd0, wbu_rd_addr}, 32'd5);
      chk("none_dnpc", wbu_dnpc, 32'h8000_0104);
      chk("none_jump", {31'd0, wbu_jump}, 32'd1);
      chk("none_branch", {31'd0, wbu_branch}, 32'd0);
      chk("none_no_req", {31'd0, mem_req_valid}, 32'd0);
      retire(0, 1'b1, 32'h0000_1234, 1'b1, 1'b0);
      exu_jump = 1'b0;
      exu_branch = 1'b1;
      exu_dnpc = 32'h8000_0200;

      // Reserved mem_op behaves as NONE
      issue(2'd3, 3'd2, 32'h0000_0055, 32'd0, 5'd6, 1'b1);
      chk("rsv_no_req", {31'd0, mem_req_valid}, 32'd0);
      chk("rsv_branch", {31'd0, wbu_branch}, 32'd1);
      retire(0, 1'b1, 32'h0000_0055, 1'b1, 1'b0);

      // LB / LBU of the top byte of 0x80ABCDEF
      issue(2'd1, 3'd0, 32'h8000_0003, 32'd0, 5'd7, 1'b1);
      serve(0, 0, 32'h80AB_CDEF, 1'b0, 1'b0, 32'h8000_0003, 1'b0, 4'b0000, 32'd0);
      retire(0, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0);
      issue(2'd1, 3'd4, 32'h8000_0003, 32'd0, 5'd7, 1'b1);
      serve(0, 0, 32'h80AB_CDEF, 1'b0, 1'b0, 32'h8000_0003, 1'b0, 4'b0000, 32'd0);
      retire(0, 1'b1, 32'h0000_0080, 1'b1, 1'b0);

      // SH to the upper halfword, SB to lane 1
      issue(2'd2, 3'd1, 32'h8000_0002, 32'h0000_BEEF, 5'd0, 1'b1);
      serve(0, 0, 32'd0, 1'b0, 1'b0, 32'h8000_0002, 1'b1, 4'b1100, 32'hBEEF_BEEF);
      retire(0, 1'b1, 32'h8000_0002, 1'b0, 1'b0);
      issue(2'd2, 3'd0, 32'h8000_0001, 32'h1234_56A5, 5'd0, 1'b0);
      serve(0, 0, 32'd0, 1'b0, 1'b0, 32'h8000_0001, 1'b1, 4'b0010, 32'hA5A5_A5A5);
      retire(0, 1'b1, 32'h8000_0001, 1'b0, 1'b0);

      // Misaligned LW and illegal funct3 load: fault, no bus request
      xfers0 = bus_xfers;
      issue(2'd1, 3'd2, 32'h8000_0001, 32'd0, 5'd8, 1'b1);
      chk("misal_no_req", {31'd0, mem_req_valid}, 32'd0);
      retire(0, 1'b0, 32'd0, 1'b0, 1'b1);
      issue(2'd1, 3'd3, 32'h8000_0000, 32'd0, 5'd8, 1'b1);
      chk("f3_3_no_req", {31'd0, mem_req_valid}, 32'd0);
      retire(0, 1'b0, 32'd0, 1'b0, 1'b1);
      chk("fault_no_bus", bus_xfers - xfers0, 32'd0);

      // Backpressure everywhere, stray response during REQ
      xfers0 = bus_xfers;
      issue(2'd1, 3'd1, 32'h8000_0002, 32'd0, 5'd3, 1'b1);
      serve(3, 2, 32'h9234_5678, 1'b0, 1'b1, 32'h8000_0002, 1'b0, 4'b0000, 32'd0);
      retire(4, 1'b1, 32'hFFFF_9234, 1'b1, 1'b0);
      chk("bp_one_xfer", bus_xfers - xfers0, 32'd1);

      // Bus error on a word load
      issue(2'd1, 3'd2, 32'h8000_0008, 32'd0, 5'd9, 1'b1);
      serve(0, 0, 32'h1111_1111, 1'b1, 1'b0, 32'h8000_0008, 1'b0, 4'b0000, 32'd0);
      retire(0, 1'b0, 32'd0, 1'b0, 1'b1);

      // Reset while waiting for a response; the late response must be ignored
      issue(2'd1, 3'd2, 32'h8000_0010, 32'd0, 5'd10, 1'b1);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      reset = 1'b0;
      tick();
      chk("midrst_wbu_valid", {31'd0, wbu_valid}, 32'd0);
      chk("midrst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      chk("midrst_req_addr", mem_req_addr, 32'd0);
      chk("midrst_alu_res", wbu_alu_res, 32'd0);
      chk("midrst_rd", {27'd0, wbu_rd_addr}, 32'd0);
      chk("midrst_exu_ready", {31'd0, exu_ready}, 32'd1);
      reset = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'hCAFE_F00D;
      tick();
      mem_resp_valid = 1'b0;
      chk("late_resp_wbu_valid", {31'd0, wbu_valid}, 32'd0);
      chk("late_resp_exu_ready", {31'd0, exu_ready}, 32'd1);

      // Normal operation resumes
      issue(2'd0, 3'd0, 32'h0000_0077, 32'd0, 5'd11, 1'b1);
      retire(0, 1'b1, 32'h0000_0077, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_24080006_lsu.md
Name: ysyx_24080006_lsu

Overview:
Load/store stage of the riscv32e multicycle core, between the EXU (upstream) and the WBU (downstream). It receives an executed instruction over a valid/ready handshake and performs at most one data-memory access on a simple request/response bus. It merges the load result into the write-back value and hands the instruction to the WBU over a valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

Parameters:
None. Widths are fixed: XLEN = 32, register address = 5 bits.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset; asserted when 0
exu_valid  in  1  EXU has an instruction
exu_ready  out  1  LSU can accept; equals (state == IDLE)
exu_alu_res  in  32  ALU result; byte address when mem_op != NONE
exu_store_data  in  32  rs2 value for stores
exu_mem_op  in  2  0 = NONE, 1 = LOAD, 2 = STORE, 3 = reserved (treated as NONE)
exu_funct3  in  3  RV access size/sign encoding
exu_rd_addr  in  5  destination register
exu_wb  in  1  instruction writes rd
exu_dnpc  in  32  next pc
exu_jump  in  1  jump flag
exu_branch  in  1  taken-branch flag
wbu_valid  out  1  result available to the WBU
wbu_ready  in  1  WBU accepts
wbu_alu_res  out  32  final write-back value
wbu_rd_addr  out  5  destination register
wbu_wb  out  1  write-enable for the WBU
wbu_dnpc  out  32  forwarded dnpc
wbu_jump  out  1  forwarded jump flag
wbu_branch  out  1  forwarded branch flag
wbu_fault  out  1  access fault on this instruction
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts the request
mem_req_addr  out  32  byte address
mem_req_wen  out  1  1 = write
mem_req_wdata  out  32  lane-replicated store data
mem_req_wstrb  out  4  byte enables; 0000 for reads
mem_resp_valid  in  1  response present
mem_resp_rdata  in  32  word-aligned read data
mem_resp_err  in  1  bus error

Behaviour:
- All outputs are registered, except exu_ready, which is decoded from state.
- Reset: reset == 0 at a clock edge forces state to IDLE and sets every registered output to 0. Reset overrides everything, including mid-access; a response still outstanding after reset is ignored. The bus owner must also be reset.
- Handshake rule: a transfer occurs on a clock edge where valid && ready. A valid, once raised, holds its payload stable until the transfer.
- State IDLE (exu_ready = 1). On exu_valid, latch all exu_* fields, then branch:
  - mem_op NONE or 3: go to OUT.
  - LOAD/STORE with a legal funct3 and aligned address: go to REQ and drive the mem_req_* fields.
  - Otherwise: go to OUT with wbu_fault = 1 and wbu_wb = 0, and issue no bus request.
- Legal load funct3 values: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- Legal store funct3 values: 0 SB, 1 SH, 2 SW.
- Misaligned access: a halfword with addr[0] = 1, or a word with addr[1:0] != 0.
- State REQ: mem_req_valid = 1, with all request fields stable. On mem_req_ready, drop mem_req_valid and go to RESP.
- State RESP: wait for mem_resp_valid. mem_resp_valid is only sampled in RESP and ignored in every other state.
  - Load: wbu_alu_res = the extracted, extended data.
  - Store: wbu_alu_res = the latched alu_res, and wbu_wb = 0.
  - mem_resp_err = 1: wbu_fault = 1 and wbu_wb = 0.
  - Then go to OUT.
- State OUT: wbu_valid = 1. On wbu_ready, go to IDLE and clear wbu_valid. There is no pass-through from OUT to IDLE, so there is a one-cycle bubble between instructions.
- Store lane formatting, with a = addr[1:0]:
  - SB: wstrb = 0001 << a; wdata = byte replicated into all 4 lanes.
  - SH: wstrb = 0011 << (2 * a[1]); wdata = halfword replicated.
  - SW: wstrb = 1111; wdata = store_data.
- Load extraction: byte = rdata[8a +: 8]; half = rdata[16 a[1] +: 16]. LB and LH sign-extend; LBU and LHU zero-extend.
- mem_req_addr is the full byte address for both reads and writes.
- Latency (accept edge = t):
  - NONE: wbu_valid is high from t+1.
  - Memory access with zero wait states: mem_req_valid from t+1, response at t+2, wbu_valid at t+3.
- Simultaneous events: exu_valid arriving in REQ, RESP, or OUT is not accepted (exu_ready = 0). A wbu_ready held high before OUT has no effect.

Decomposition:
- Package ysyx_24080006_pkg holds:
  - mem_op_e (NONE / LOAD / STORE)
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - lsu_state_e (IDLE / REQ / RESP / OUT)
- One combinational sub-module, ysyx_24080006_lsu_align. It computes:
  - the misaligned / illegal-funct3 flag;
  - wstrb and wdata from (funct3, addr[1:0], store_data);
  - the extended load value from (funct3, addr[1:0], rdata).
- The FSM and registers stay in the top module.

Test Plan:
- Reset with exu_valid = 1, then release reset → all outputs stay 0 and exu_ready = 1. A NONE instruction with alu_res = 0x1234, rd = 5, wb = 1 → wbu_valid one cycle later with alu_res 0x1234, wb = 1.
- LB at addr 0x8000_0003, memory rdata = 0x80AB_CDEF → wbu_alu_res = 0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- SH at 0x8000_0002, store_data = 0x0000_BEEF → mem_req_wstrb = 1100, wdata = 0xBEEF_BEEF, wen = 1; wbu_wb = 0.
- LW at 0x8000_0001 → no mem_req_valid; wbu_fault = 1, wbu_wb = 0. Also funct3 = 3 on a LOAD → fault.
- Backpressure: mem_req_ready low for 3 cycles, then the response is delayed 2 cycles; wbu_ready low for 4 cycles → request fields stable throughout, wbu_valid stable, exactly one bus transaction; a spurious mem_resp_valid during REQ is ignored.
- LW with mem_resp_err = 1 → wbu_fault = 1, wb = 0. Reset asserted while in RESP → back to IDLE with outputs 0, and the late response is ignored.
